// File: rtl/gpr_file_if.sv
`default_nettype none
// ============================================================================
// Module      : gpr_file_if
// Description : Bus bundle for gpr_file: clear/busy control, one write port,
//               one reserve port and two combinational read ports.
// Revision    : 1.0 - initial release
// ============================================================================
interface gpr_file_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
);
    logic                  Clear;
    logic                  Busy;
    logic                  WrEn;
    logic [ADDR_WIDTH-1:0] WrAddr;
    logic [DATA_WIDTH-1:0] WrData;
    logic                  ResvEn;
    logic [ADDR_WIDTH-1:0] ResvAddr;
    logic [ADDR_WIDTH-1:0] RdAddrA;
    logic [DATA_WIDTH-1:0] RdDataA;
    logic                  PendA;
    logic [ADDR_WIDTH-1:0] RdAddrB;
    logic [DATA_WIDTH-1:0] RdDataB;
    logic                  PendB;

    // Requester side: drives commands and addresses, observes results.
    modport master (
        output Clear, WrEn, WrAddr, WrData, ResvEn, ResvAddr, RdAddrA, RdAddrB,
        input  Busy, RdDataA, PendA, RdDataB, PendB
    );

    // Register file side.
    modport slave (
        input  Clear, WrEn, WrAddr, WrData, ResvEn, ResvAddr, RdAddrA, RdAddrB,
        output Busy, RdDataA, PendA, RdDataB, PendB
    );
endinterface
`default_nettype wire

// File: rtl/gpr_file.sv
`default_nettype none
// ============================================================================
// Module      : gpr_file
// Description : General-purpose register file, 2 combinational read ports,
//               1 synchronous write port, optional zero register and
//               write-to-read bypass, per-register pending-write scoreboard
//               and a sequential clear engine that zeroes the array.
// Revision    : 1.0 - initial release
// ============================================================================
module gpr_file #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic      Clock,
    input  logic      nReset,
    gpr_file_if.slave bus
);

    localparam int                    DEPTH = 1 << ADDR_WIDTH;
    // Register 0 never needs sweeping when it is hard-wired to zero.
    localparam logic [ADDR_WIDTH-1:0] FIRST = (ZERO_REG != 0) ? ADDR_WIDTH'(1) : '0;
    localparam logic [ADDR_WIDTH-1:0] LAST  = '1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic                  busy_q, busy_d;
    logic [DEPTH-1:0]      pend_q, pend_d;
    logic                  clr_pend;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_wa;
    logic [DATA_WIDTH-1:0] mem_wd;

    logic                  wr_ok;
    logic                  resv_ok;
    logic [DATA_WIDTH-1:0] rd_data_a, rd_data_b;
    logic                  rd_pend_a, rd_pend_b;

    // Qualify write and reserve: blocked while sweeping and on the zero register.
    always_comb begin
        wr_ok   = bus.WrEn   && !busy_q && !((ZERO_REG != 0) && (bus.WrAddr   == '0));
        resv_ok = bus.ResvEn && !busy_q && !((ZERO_REG != 0) && (bus.ResvAddr == '0));
    end

    // Clear engine next state: a Clear in either state (re)starts the sweep.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        clr_pend = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.Clear) begin
                    state_d  = ST_SWEEP;
                    idx_d    = FIRST;
                    clr_pend = 1'b1;
                end
            end
            ST_SWEEP: begin
                if (bus.Clear) begin
                    idx_d    = FIRST;
                    clr_pend = 1'b1;
                end else if (idx_q == LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_SWEEP);
    end

    // Scoreboard next state: reserve is applied after write so it wins a same-address collision.
    always_comb begin
        pend_d = pend_q;
        if (clr_pend) begin
            pend_d = '0;
        end else begin
            if (wr_ok) begin
                pend_d[bus.WrAddr] = 1'b0;
            end
            if (resv_ok) begin
                pend_d[bus.ResvAddr] = 1'b1;
            end
        end
    end

    // Control state, busy flag and scoreboard; reset restarts the sweep.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= ST_SWEEP;
            idx_q   <= FIRST;
            busy_q  <= 1'b1;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            pend_q  <= pend_d;
        end
    end

    // Single array write port shared by the sweep (writes zero) and normal writes.
    always_comb begin
        mem_we = busy_q || wr_ok;
        mem_wa = busy_q ? idx_q : bus.WrAddr;
        mem_wd = busy_q ? '0    : bus.WrData;
    end

    // Register array: not reset, the sweep is what initialises it.
    always_ff @(posedge Clock) begin
        if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    // Read port A: zero register, then bypass, then array.
    always_comb begin
        rd_data_a = '0;
        rd_pend_a = 1'b0;
        if (!busy_q && !((ZERO_REG != 0) && (bus.RdAddrA == '0))) begin
            if ((BYPASS != 0) && wr_ok && (bus.WrAddr == bus.RdAddrA)) begin
                rd_data_a = bus.WrData;
            end else begin
                rd_data_a = mem_q[bus.RdAddrA];
                rd_pend_a = pend_q[bus.RdAddrA];
            end
        end
    end

    // Read port B: identical selection to port A.
    always_comb begin
        rd_data_b = '0;
        rd_pend_b = 1'b0;
        if (!busy_q && !((ZERO_REG != 0) && (bus.RdAddrB == '0))) begin
            if ((BYPASS != 0) && wr_ok && (bus.WrAddr == bus.RdAddrB)) begin
                rd_data_b = bus.WrData;
            end else begin
                rd_data_b = mem_q[bus.RdAddrB];
                rd_pend_b = pend_q[bus.RdAddrB];
            end
        end
    end

    assign bus.Busy    = busy_q;
    assign bus.RdDataA = rd_data_a;
    assign bus.PendA   = rd_pend_a;
    assign bus.RdDataB = rd_data_b;
    assign bus.PendB   = rd_pend_b;

endmodule
`default_nettype wire

// File: doc/gpr_file.md
Name: gpr_file

Overview:
- Parametrised general-purpose register file for the datapath: 2 combinational read ports, 1 synchronous write port.
- Optional hard-wired zero register and write-to-read bypass.
- Per-register pending-write scoreboard for hazard detection.
- Sequential clear engine that zeroes the array after reset or on request.
- Read outputs are point-to-point; there are no tristate outputs.

Parameters:
DATA_WIDTH, 16, register width in bits.
ADDR_WIDTH, 3, address width; DEPTH = 1 << ADDR_WIDTH.
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes and reserves.
BYPASS, 1, 1 = a same-cycle write is forwarded to a matching read port.

Ports:
Clock  input  1  rising-edge clock.
nReset  input  1  asynchronous, active-low reset.
Clear  input  1  one-cycle request to zero all registers and the scoreboard.
Busy  output  1  clear sweep in progress; writes and reserves are ignored.
WrEn  input  1  write strobe.
WrAddr  input  ADDR_WIDTH  write address.
WrData  input  DATA_WIDTH  write data.
ResvEn  input  1  mark the register at ResvAddr as pending.
ResvAddr  input  ADDR_WIDTH  register to reserve.
RdAddrA  input  ADDR_WIDTH  read port A address.
RdDataA  output  DATA_WIDTH  read port A data.
PendA  output  1  register at RdAddrA is awaiting a write.
RdAddrB  input  ADDR_WIDTH  read port B address.
RdDataB  output  DATA_WIDTH  read port B data.
PendB  output  1  register at RdAddrB is awaiting a write.

Behaviour:
- Clock domain: one clock (Clock). Reset nReset is asynchronous and active-low.
- Reset values (while nReset = 0):
  - FSM = SWEEP, sweep index = FIRST, where FIRST = 1 if ZERO_REG else 0.
  - Busy = 1, all pending bits = 0, PendA = PendB = 0, RdDataA = RdDataB = 0.
  - The array itself is not reset; the sweep zeroes it.
- FSM states:
  - IDLE: Busy = 0. Clear = 1 -> SWEEP, index = FIRST, all pending bits cleared at the same edge.
  - SWEEP: Busy = 1. Each edge writes 0 to mem[index], then index + 1.
    - Edge that writes index DEPTH-1 -> IDLE.
    - Clear = 1 during SWEEP restarts index at FIRST.
- Sweep timing after nReset rises:
  - ZERO_REG = 1: DEPTH-1 edges.
  - ZERO_REG = 0: DEPTH edges.
  - Busy falls after the final sweep edge.
- Reads while Busy = 1: RdData = 0 and Pend = 0.
- Write:
  - At the edge, when WrEn = 1, Busy = 0, and not (ZERO_REG and WrAddr = 0): mem[WrAddr] <= WrData and pend[WrAddr] <= 0.
  - Otherwise the write is silently dropped.
- Reserve:
  - At the edge, when ResvEn = 1, Busy = 0, and not (ZERO_REG and ResvAddr = 0): pend[ResvAddr] <= 1.
  - Same-edge WrEn and ResvEn to the same address: reserve wins, so pend = 1 and the data is still written.
- Read (combinational, per port X in {A, B}):
  - ZERO_REG and RdAddrX = 0 -> RdDataX = 0, PendX = 0.
  - Else BYPASS and a valid write this cycle with WrAddr = RdAddrX -> RdDataX = WrData, PendX = 0.
  - Else RdDataX = mem[RdAddrX], PendX = pend[RdAddrX].
- Both ports may read the same address simultaneously; results are identical.
- No read-port latency; write-to-read latency is 0 with BYPASS and 1 cycle without.
- Assertion of nReset mid-sweep or mid-operation: FSM and scoreboard reset immediately and the sweep restarts once nReset rises.

Test Plan:
1. Reset, then release with defaults -> Busy high for exactly 7 edges. Afterwards, reading r1..r7 on both ports returns 0x0000 and PendA = PendB = 0.
2. Write r3 = 0xBEEF with RdAddrA = 3 in the same cycle -> RdDataA = 0xBEEF combinationally (bypass). Next cycle with WrEn = 0 -> 0xBEEF from the array. With BYPASS = 0, the same-cycle read returns the old value 0x0000.
3. Write r0 = 0x1234 and reserve r0 -> RdDataA/B = 0 and PendA = 0. Repeat with ZERO_REG = 0 -> r0 reads 0x1234.
4. Reserve r5 -> PendB = 1 for RdAddrB = 5. Write r5 = 0x00AA -> PendB = 0 after the edge. Same-edge reserve and write on r5 = 0x0055 -> data 0x0055, PendB = 1.
5. Load r1..r7 with nonzero values, pulse Clear -> Busy = 1 for 7 cycles. A WrEn r2 = 0xFFFF mid-sweep is dropped, and all registers read 0 afterwards. A second Clear pulse mid-sweep extends Busy to 7 cycles from that pulse.
6. DATA_WIDTH = 32, ADDR_WIDTH = 4: assert nReset mid-sweep -> Busy stays high and the sweep restarts. Busy is high for 15 edges after release, then write and read r15 = 0xDEADBEEF succeeds.
